delay_counter_arbiter: RTL and testbench

- Shares one WIDTH-bit counter register among N_REQ requesters.
- Each requester issues INC, LOAD, CLEAR or READ operations.
- A round-robin arbiter grants one operation per cycle and applies it at the clock edge.
- The pre-operation value is returned one cycle later, tagged with the requester id.
- Sits between the delay/timestamp consumers and the shared counter; it replaces per-consumer private counters.

---
 rtl/delay_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/delay_counter_arbiter.sv | 169 ++++++++++++++++
 tb/tb_delay_counter_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
// Module     : delay_pkg
// Description: Shared definitions for the shared delay/timestamp counter:
//              operation encodings, default data width and a constant-safe
//              ceiling-log2 helper used to size requester indices.
// Revision   : 1.0 - initial release
// ============================================================================
package delay_pkg;

    // Default counter / operand width
    localparam int DEFAULT_WIDTH = 32;

    // Two-bit operation encoding carried on each requester's op slice
    typedef logic [1:0] op_t;

    localparam op_t OP_READ  = 2'd0;
    localparam op_t OP_INC   = 2'd1;
    localparam op_t OP_LOAD  = 2'd2;
    localparam op_t OP_CLEAR = 2'd3;

    // Ceiling log2; returns 0 for value <= 1. Usable in parameter context.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage : delay_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rr_arbiter
// Description: Purely combinational round-robin grant logic. Picks the first
//              asserted request searching upward from i_ptr, wrapping modulo N.
//              The priority pointer itself is owned and advanced by the parent.
// Revision   : 1.0 - initial release
//
// Ports:
//   i_valid  in   N      request vector
//   i_ptr    in   IDX_W  highest-priority index this cycle (must be < N)
//   o_grant  out  N      one-hot grant (all zero when nothing is requested)
//   o_idx    out  IDX_W  encoded index of the granted request
//   o_any    out  1      at least one request is granted
// ============================================================================
import delay_pkg::*;

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0]     w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk the priority order ptr, ptr+1, ... (mod N). The inner loop matches
    // the rotated position against constant indices so every select into
    // i_valid / w_grant stays constant after unrolling.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && i_valid[j] && (j == ((int'(i_ptr) + k) % N))) begin
                    w_found    = 1'b1;
                    w_grant[j] = 1'b1;
                    w_idx      = IDX_W'(j);
                end
            end
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;
    assign o_any   = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/delay_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : delay_counter_arbiter
// Description: One WIDTH-bit counter shared by N_REQ requesters. A round-robin
//              arbiter grants one READ/INC/LOAD/CLEAR per cycle; the operation
//              takes effect at that clock edge and the pre-operation value is
//              returned one cycle later, tagged with the requester index.
//              A sticky flag records any INC that carried out of the counter.
// Revision   : 1.0 - initial release
//
// Ports:
//   clk            in   1            rising-edge clock
//   reset          in   1            asynchronous, active-low reset
//   io_req_valid   in   N_REQ        per-requester valid
//   io_req_ready   out  N_REQ        one-hot grant (zero while in reset)
//   io_req_op      in   2*N_REQ      op slice i = [2i+1:2i]
//   io_req_data    in   WIDTH*N_REQ  operand slice i (LOAD value / INC step)
//   io_resp_valid  out  1            one-cycle pulse per accepted op
//   io_resp_id     out  ID_W         granted requester index
//   io_resp_data   out  WIDTH        counter value before the granted op
//   io_count       out  WIDTH        live counter value
//   io_overflow    out  1            sticky INC carry-out flag
//   io_ovf_clear   in   1            clears io_overflow (a same-cycle set wins)
// ============================================================================
import delay_pkg::*;

module delay_counter_arbiter #(
    parameter int               N_REQ     = 4,
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               ID_W      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       io_req_valid,
    output logic [N_REQ-1:0]       io_req_ready,
    input  logic [2*N_REQ-1:0]     io_req_op,
    input  logic [WIDTH*N_REQ-1:0] io_req_data,
    output logic                   io_resp_valid,
    output logic [ID_W-1:0]        io_resp_id,
    output logic [WIDTH-1:0]       io_resp_data,
    output logic [WIDTH-1:0]       io_count,
    output logic                   io_overflow,
    input  logic                   io_ovf_clear
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic [ID_W-1:0]  r_ptr;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [WIDTH-1:0] r_resp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic             w_xfer;
    logic [ID_W-1:0]  w_ptr_next;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .i_valid (io_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants are masked while reset is held so no requester sees a
    // handshake that the (held) registers cannot honour.
    assign io_req_ready = reset ? w_grant : '0;
    assign w_xfer       = w_any & reset;

    // Next priority position is one past the winner, wrapping at N_REQ
    // (N_REQ need not be a power of two).
    assign w_ptr_next = (w_idx == ID_W'(N_REQ - 1)) ? '0 : (w_idx + 1'b1);

    // ------------------------------------------------------------------
    // Select the winner's op and operand
    // ------------------------------------------------------------------
    op_t              w_op;
    logic [WIDTH-1:0] w_data;

    always_comb begin
        w_op   = OP_READ;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_op   = io_req_op[2*i +: 2];
                w_data = io_req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_count_next;
    logic             w_set_ovf;

    // One extra bit captures the carry out of the INC add.
    assign w_sum = {1'b0, r_count} + {1'b0, w_data};

    always_comb begin
        w_count_next = r_count;
        w_set_ovf    = 1'b0;
        if (w_xfer) begin
            case (w_op)
                OP_INC: begin
                    w_count_next = w_sum[WIDTH-1:0];
                    w_set_ovf    = w_sum[WIDTH];
                end
                OP_LOAD:  w_count_next = w_data;
                OP_CLEAR: w_count_next = RESET_VAL;
                default:  w_count_next = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= RESET_VAL;
            r_overflow   <= 1'b0;
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            r_count <= w_count_next;

            // A carry in the same cycle as a clear request keeps the flag set.
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (io_ovf_clear) begin
                r_overflow <= 1'b0;
            end

            r_resp_valid <= w_xfer;
            if (w_xfer) begin
                r_resp_id   <= w_idx;
                r_resp_data <= r_count;
                r_ptr       <= w_ptr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_resp_valid = r_resp_valid;
    assign io_resp_id    = r_resp_id;
    assign io_resp_data  = r_resp_data;
    assign io_count      = r_count;
    assign io_overflow   = r_overflow;

endmodule : delay_counter_arbiter
`default_nettype wire

// File: tb/tb_delay_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_delay_counter_arbiter
// Description: Directed self-checking bench for delay_counter_arbiter.
//              Expected responses are queued when a grant is issued and a
//              separate monitor pops and compares them as responses appear.
// Revision   : 1.0 - initial release
// ============================================================================
import delay_pkg::*;

module tb_delay_counter_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   valid;
    logic [N-1:0]   ready;
    logic [2*N-1:0] op;
    logic [W*N-1:0] data;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;
    logic [W-1:0]   count;
    logic           ovf;
    logic           ovf_clear;

    delay_counter_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .ID_W      (2),
        .RESET_VAL ('0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_req_valid  (valid),
        .io_req_ready  (ready),
        .io_req_op     (op),
        .io_req_data   (data),
        .io_resp_valid (resp_valid),
        .io_resp_id    (resp_id),
        .io_resp_data  (resp_data),
        .io_count      (count),
        .io_overflow   (ovf),
        .io_ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding grant
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got id=%0d data=%0h, expected no response (t=%0t)",
                         resp_id, resp_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_id",    64'(resp_id),   64'(mon_e.id));
                check("resp_data",  64'(resp_data), 64'(mon_e.data));
                check("resp_cycle", 64'(cyc),       64'(mon_e.due));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clr_reqs();
        valid = '0;
        op    = '0;
        data  = '0;
    endtask

    task automatic set_req(input int r, input logic [1:0] o, input logic [31:0] d);
        valid[r]        = 1'b1;
        op[2*r +: 2]    = o;
        data[W*r +: W]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect requester g to be granted now; queue its response (pre-op value).
    task automatic grant(input string name, input int g, input logic [31:0] pre);
        logic [N-1:0] m;
        #1;
        m = 4'b0001 << g;
        check(name, 64'(ready), 64'(m));
        exp_q.push_back('{id: 2'(g), data: pre, due: cyc + 1});
    endtask

    task automatic check_state(input string name, input logic [31:0] c, input logic o);
        check({name, "_count"}, 64'(count), 64'(c));
        check({name, "_ovf"},   64'(ovf),   64'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        ovf_clear = 1'b0;
        clr_reqs();
        valid     = 4'hF;               // ready must stay low despite requests
        #2;
        check("rst_ready",      64'(ready),      64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_data",  64'(resp_data),  64'(0));
        check_state("rst", 32'd0, 1'b0);
        #20;
        valid = '0;
        reset = 1'b1;
        step();

        // Idle after reset
        repeat (5) begin
            check("idle_ready",      64'(ready),      64'(0));
            check("idle_resp_valid", 64'(resp_valid), 64'(0));
            check_state("idle", 32'd0, 1'b0);
            step();
        end

        // Requester 2: INC 5, INC 3, READ
        clr_reqs(); set_req(2, OP_INC, 32'd5);  grant("r2_inc5", 2, 32'd0); step();
        check_state("r2_inc5", 32'd5, 1'b0);
        clr_reqs(); set_req(2, OP_INC, 32'd3);  grant("r2_inc3", 2, 32'd5); step();
        check_state("r2_inc3", 32'd8, 1'b0);
        clr_reqs(); set_req(2, OP_READ, 32'd0); grant("r2_read", 2, 32'd8); step();
        check_state("r2_read", 32'd8, 1'b0);
        clr_reqs(); step();

        // Pointer sits at 3; one grant to requester 3 returns it to 0
        set_req(3, OP_READ, 32'd0); grant("r3_read", 3, 32'd8); step();

        // Fairness: all four READ continuously
        for (int k = 0; k < 8; k++) begin
            clr_reqs();
            for (int r = 0; r < N; r++) set_req(r, OP_READ, 32'hDEAD_0000 + r);
            grant("rr_fair", k % 4, 32'd8);
            step();
        end
        clr_reqs(); step();

        // Wrap and sticky overflow (pointer at 0)
        set_req(0, OP_LOAD, 32'hFFFF_FFFE); grant("wrap_load", 0, 32'd8); step();
        check_state("wrap_load", 32'hFFFF_FFFE, 1'b0);
        clr_reqs(); set_req(0, OP_INC, 32'd3); grant("wrap_inc3", 0, 32'hFFFF_FFFE); step();
        check_state("wrap_inc3", 32'd1, 1'b1);
        clr_reqs(); ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
        check_state("ovf_clear", 32'd1, 1'b0);
        set_req(0, OP_LOAD, 32'hFFFF_FFFF); grant("wrap_load2", 0, 32'd1); step();
        clr_reqs(); set_req(0, OP_INC, 32'd1); ovf_clear = 1'b1;
        grant("wrap_inc_clr", 0, 32'hFFFF_FFFF); step(); ovf_clear = 1'b0;
        check_state("set_beats_clr", 32'd0, 1'b1);
        clr_reqs(); ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
        check_state("ovf_clear2", 32'd0, 1'b0);
        set_req(0, OP_LOAD, 32'hFFFF_FFFF); grant("load_max", 0, 32'd0); step();
        clr_reqs(); set_req(0, OP_INC, 32'd0); grant("inc_zero", 0, 32'hFFFF_FFFF); step();
        check_state("inc_zero", 32'hFFFF_FFFF, 1'b0);
        clr_reqs(); step();

        // Skip idle requesters: move pointer to 2 via requester 1
        set_req(1, OP_READ, 32'd0); grant("skip_pre", 1, 32'hFFFF_FFFF); step();
        for (int k = 0; k < 4; k++) begin
            clr_reqs();
            set_req(1, OP_READ, 32'd0);
            set_req(3, OP_READ, 32'd0);
            grant("skip_idle", (k % 2 == 0) ? 3 : 1, 32'hFFFF_FFFF);
            step();
        end
        clr_reqs(); step();

        // Back-to-back ops with reset dropped between edges (pointer at 2)
        set_req(1, OP_LOAD, 32'd10); grant("b2b_load", 1, 32'hFFFF_FFFF); step();
        clr_reqs(); set_req(1, OP_INC, 32'd1); grant("b2b_inc1", 1, 32'd10); step();
        check_state("b2b_inc1", 32'd11, 1'b0);
        clr_reqs(); set_req(1, OP_INC, 32'd1); grant("b2b_inc2", 1, 32'd11); step();
        clr_reqs(); set_req(1, OP_INC, 32'd1);
        #1;
        reset = 1'b0;
        exp_q.delete();                 // the in-flight response is discarded
        #1;
        check("arst_ready",      64'(ready),      64'(0));
        check("arst_resp_valid", 64'(resp_valid), 64'(0));
        check_state("arst", 32'd0, 1'b0);
        @(negedge clk); #1;
        check("arst_hold_ready", 64'(ready), 64'(0));
        check_state("arst_hold", 32'd0, 1'b0);

        clr_reqs();
        set_req(0, OP_READ, 32'd0);
        set_req(2, OP_READ, 32'd0);
        reset = 1'b1;
        grant("post_rst_first", 0, 32'd0); step();
        grant("post_rst_second", 2, 32'd0); step();
        clr_reqs(); step(); step();

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_delay_counter_arbiter
`default_nettype wire
